// File: rtl/sd_spi_responder.sv
// sd_spi_responder
//   Card side of an SPI-mode SD link. Decodes 6-byte command frames from the
//   host and answers on spi_miso. CMD17 single-block reads are served from an
//   external synchronous byte memory.
//
// Ports
//   clk, reset         system clock, asynchronous active-high reset
//   spi_ss/sck/mosi    host SPI pins (mode 0, asynchronous to clk)
//   spi_miso           card-to-host data
//   mem_blk, mem_idx   block address / byte index presented to the memory
//   mem_din            memory data, valid 1 clk after mem_blk/mem_idx change
//   cmd_valid          one-cycle pulse per completed frame; cmd_index and
//                      cmd_arg are updated on the same cycle and hold until
//                      the next frame (no ready: the consumer must sample it)
//   busy               FSM is outside S_IDLE
//   card_idle          R1 in-idle-state bit
module sd_spi_responder #(
  parameter int NCR_BYTES  = 1,
  parameter int INIT_POLLS = 2,
  parameter int TOKEN_GAP  = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        spi_ss,
  input  logic        spi_sck,
  input  logic        spi_mosi,
  output logic        spi_miso,
  output logic [31:0] mem_blk,
  output logic [8:0]  mem_idx,
  input  logic [7:0]  mem_din,
  output logic        cmd_valid,
  output logic [5:0]  cmd_index,
  output logic [31:0] cmd_arg,
  output logic        busy,
  output logic        card_idle
);

  localparam logic [9:0] NCR_LAST = 10'(NCR_BYTES - 1);
  localparam logic [9:0] GAP_LAST = (TOKEN_GAP > 0) ? 10'(TOKEN_GAP - 1) : 10'd0;
  localparam logic [7:0] POLLS_N  = 8'(INIT_POLLS);

  typedef enum logic [2:0] {
    S_IDLE, S_CMD, S_NCR, S_RESP, S_GAP, S_TOKEN, S_DATA, S_CRC
  } state_t;

  state_t      state_q, state_d;
  logic [2:0]  sck_q;          // [0],[1] synchronizer, [2] previous value for edges
  logic [1:0]  mosi_q, ss_q;
  logic [2:0]  bit_cnt_q;
  logic [6:0]  rx_shift_q;
  logic [7:0]  tx_shift_q, tx_byte;
  logic [9:0]  cnt_q;
  logic [5:0]  idx_q, cmd_index_q;
  logic [31:0] arg_sh_q, cmd_arg_q, mem_blk_q;
  logic [8:0]  mem_idx_q;
  logic [7:0]  data_q, polls_q, r1;
  logic        cmd_valid_q, card_idle_q, app_q, illegal_q, resp_long_q, data_go_q;
  logic        rise_ev, fall_ev, ss_hi, byte_done, frame_end;
  logic [7:0]  rx_byte;
  logic [9:0]  resp_last;

  assign rise_ev   = sck_q[1] & ~sck_q[2];
  assign fall_ev   = ~sck_q[1] & sck_q[2];
  assign ss_hi     = ss_q[1];
  assign rx_byte   = {rx_shift_q, mosi_q[1]};
  assign byte_done = rise_ev & ~ss_hi & (bit_cnt_q == 3'd7);
  assign frame_end = byte_done & (state_q == S_CMD) & (cnt_q == 10'd4);
  assign resp_last = resp_long_q ? 10'd4 : 10'd0;
  assign r1        = {5'b00000, illegal_q, 1'b0, card_idle_q};

  assign spi_miso  = tx_shift_q[7];
  assign mem_blk   = mem_blk_q;
  assign mem_idx   = mem_idx_q;
  assign cmd_valid = cmd_valid_q;
  assign cmd_index = cmd_index_q;
  assign cmd_arg   = cmd_arg_q;
  assign card_idle = card_idle_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sck_q  <= 3'b000;
      mosi_q <= 2'b00;
      ss_q   <= 2'b11;
    end else begin
      sck_q  <= {sck_q[1:0], spi_sck};
      mosi_q <= {mosi_q[0], spi_mosi};
      ss_q   <= {ss_q[0], spi_ss};
    end
  end

  // Bit engine: sample on rise, load a new TX byte on the first fall of a byte
  // (bit_cnt==0), shift on every other fall. Deselect parks MISO high.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bit_cnt_q  <= 3'd0;
      rx_shift_q <= 7'd0;
      tx_shift_q <= 8'hFF;
    end else if (ss_hi) begin
      bit_cnt_q  <= 3'd0;
      tx_shift_q <= 8'hFF;
    end else begin
      if (rise_ev) begin
        bit_cnt_q  <= bit_cnt_q + 3'd1;
        rx_shift_q <= {rx_shift_q[5:0], mosi_q[1]};
      end
      if (fall_ev) begin
        if (bit_cnt_q == 3'd0) tx_shift_q <= tx_byte;
        else                   tx_shift_q <= {tx_shift_q[6:0], 1'b1};
      end
    end
  end

  // FSM: state register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  // FSM: next state. Every transition happens on a byte boundary; cnt_q counts
  // completed bytes within the current state.
  always_comb begin
    state_d = state_q;
    if (ss_hi) begin
      state_d = S_IDLE;
    end else if (byte_done) begin
      case (state_q)
        S_IDLE:  if (rx_byte[7:6] == 2'b01) state_d = S_CMD;
        S_CMD:   if (cnt_q == 10'd4) state_d = S_NCR;
        S_NCR:   if (cnt_q == NCR_LAST) state_d = S_RESP;
        S_RESP:  if (cnt_q == resp_last) begin
                   if (!data_go_q)          state_d = S_IDLE;
                   else if (TOKEN_GAP == 0) state_d = S_TOKEN;
                   else                     state_d = S_GAP;
                 end
        S_GAP:   if (cnt_q == GAP_LAST) state_d = S_TOKEN;
        S_TOKEN: state_d = S_DATA;
        S_DATA:  if (cnt_q == 10'd511) state_d = S_CRC;
        S_CRC:   if (cnt_q == 10'd1) state_d = S_IDLE;
        default: state_d = S_IDLE;
      endcase
    end
  end

  // FSM: outputs (next TX byte and busy)
  always_comb begin
    tx_byte = 8'hFF;
    busy    = (state_q != S_IDLE);
    case (state_q)
      S_RESP: begin
        if (cnt_q == 10'd0) begin
          tx_byte = r1;
        end else if (cmd_index_q == 6'd8) begin
          case (cnt_q[2:0])
            3'd3:    tx_byte = {4'h0, cmd_arg_q[11:8]};
            3'd4:    tx_byte = cmd_arg_q[7:0];
            default: tx_byte = 8'h00;
          endcase
        end else begin
          case (cnt_q[2:0])
            3'd1:    tx_byte = 8'hC0;
            3'd2:    tx_byte = 8'hFF;
            3'd3:    tx_byte = 8'h80;
            default: tx_byte = 8'h00;
          endcase
        end
      end
      S_TOKEN: tx_byte = 8'hFE;
      S_DATA:  tx_byte = data_q;
      default: tx_byte = 8'hFF;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset)                  cnt_q <= 10'd0;
    else if (state_d != state_q) cnt_q <= 10'd0;
    else if (byte_done)          cnt_q <= cnt_q + 10'd1;
  end

  // Command capture, card state and memory addressing
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      idx_q       <= 6'd0;
      arg_sh_q    <= 32'd0;
      cmd_index_q <= 6'd0;
      cmd_arg_q   <= 32'd0;
      cmd_valid_q <= 1'b0;
      card_idle_q <= 1'b1;
      app_q       <= 1'b0;
      illegal_q   <= 1'b0;
      resp_long_q <= 1'b0;
      data_go_q   <= 1'b0;
      polls_q     <= 8'd0;
      mem_blk_q   <= 32'd0;
      mem_idx_q   <= 9'd0;
      data_q      <= 8'd0;
    end else begin
      cmd_valid_q <= frame_end;
      data_q      <= mem_din;
      if (byte_done && state_q == S_IDLE && rx_byte[7:6] == 2'b01)
        idx_q <= rx_byte[5:0];
      if (byte_done && state_q == S_CMD && cnt_q < 10'd4)
        arg_sh_q <= {arg_sh_q[23:0], rx_byte};
      // mem_idx always points at the byte to be loaded at the next boundary
      if (byte_done && state_q == S_DATA)
        mem_idx_q <= mem_idx_q + 9'd1;
      if (frame_end) begin
        cmd_index_q <= idx_q;
        cmd_arg_q   <= arg_sh_q;
        app_q       <= (idx_q == 6'd55);
        illegal_q   <= 1'b0;
        resp_long_q <= 1'b0;
        data_go_q   <= 1'b0;
        case (idx_q)
          6'd0: begin
            card_idle_q <= 1'b1;
            polls_q     <= 8'd0;
          end
          6'd8, 6'd58: resp_long_q <= 1'b1;
          6'd16, 6'd55: ;
          6'd41: begin
            if (app_q) begin
              if (polls_q != 8'hFF) polls_q <= polls_q + 8'd1;
              if (polls_q + 8'd1 >= POLLS_N) card_idle_q <= 1'b0;
            end else begin
              illegal_q <= 1'b1;
            end
          end
          6'd17: begin
            mem_blk_q <= arg_sh_q;
            mem_idx_q <= 9'd0;
            if (card_idle_q) illegal_q <= 1'b1;
            else             data_go_q <= 1'b1;
          end
          default: illegal_q <= 1'b1;
        endcase
      end
    end
  end

endmodule

// File: doc/sd_spi_responder.md
# sd_spi_responder

SPI-mode SD-card responder: the card side of the link that `sd_card` drives. It decodes command frames from the host on spi_ss/spi_sck/spi_mosi and answers on spi_miso. CMD17 single-block reads are served from an external synchronous byte memory. It is used as an on-board or simulation stand-in for a physical card, so sector-reader designs can run against known sector contents.

## Interface
- NCR_BYTES, 1: number of 0xFF bytes between the end of a command frame and the first response byte (1..8).
- INIT_POLLS, 2: number of ACMD41 commands required before card_idle clears; the last one answers 0x00.
- TOKEN_GAP, 2: number of 0xFF bytes between the CMD17 R1 and the 0xFE start token (0..15).
- clk  in  1  system clock; the only clock.
- reset  in  1  asynchronous, active-high reset.
- spi_ss  in  1  chip select, active-low.
- spi_sck  in  1  SPI clock, mode 0; asynchronous to clk.
- spi_mosi  in  1  host-to-card data, MSB first.
- spi_miso  out  1  card-to-host data.
- mem_blk  out  32  block address, latched from the CMD17 argument.
- mem_idx  out  9  byte index within the block.
- mem_din  in  8  memory data; valid 1 clk after mem_blk/mem_idx change.
- cmd_valid  out  1  one-cycle pulse when a 6-byte command frame completes.
- cmd_index  out  6  index of the last command.
- cmd_arg  out  32  argument of the last command.
- busy  out  1  high whenever the FSM is not in S_IDLE.
- card_idle  out  1  R1 in-idle-state bit.

## Operation
- spi_sck, spi_mosi and spi_ss each pass through a 2-FF synchronizer. Rise and fall events come from the synchronized spi_sck.
- bit_cnt[2:0] advances on each rise event while spi_ss is low. rx_shift shifts in spi_mosi on each rise.
- On a fall event with bit_cnt==0, tx_shift loads the next TX byte and spi_miso takes its MSB. On any other fall event, tx_shift shifts left.
- A byte is complete on the rise event where bit_cnt wraps 7->0.
- The next TX byte comes from the current state: 0xFF, a response byte, a token, mem_din, or CRC.
- When spi_ss is high: spi_miso=1, bit_cnt=0, and the FSM goes to S_IDLE. card_idle and the ACMD41 count are kept.
- States and transitions:
  - S_IDLE: TX byte 0xFF. A received byte matching 01xxxxxx -> S_CMD; any other byte is ignored.
  - S_CMD: collects 5 more bytes; the CRC byte is ignored. At frame end: cmd_valid pulses, cmd_index and cmd_arg update, then -> S_NCR.
  - S_NCR: sends NCR_BYTES bytes of 0xFF, then -> S_RESP.
  - S_RESP: sends the response bytes, then -> S_GAP for CMD17, otherwise -> S_IDLE.
  - S_GAP: sends TOKEN_GAP bytes of 0xFF, then -> S_TOKEN.
  - S_TOKEN: sends 0xFE, then -> S_DATA.
  - S_DATA: sends 512 bytes, mem_idx 0..511, then -> S_CRC.
  - S_CRC: sends 0xFF, 0xFF, then -> S_IDLE.
- Responses (R1 carries card_idle in bit 0):
  - CMD0: sets card_idle, resets the ACMD41 count; R1.
  - CMD8: R1, 0x00, 0x00, then arg[15:8] & 0x0F, then arg[7:0].
  - CMD55: R1; arms the app flag for the next command only.
  - ACMD41: count++; when count reaches INIT_POLLS, card_idle clears before R1 is sent.
  - CMD58: R1, 0xC0, 0xFF, 0x80, 0x00.
  - CMD16: R1.
  - CMD17: R1 0x00 when card_idle is 0. If card_idle is 1, answers 0x05 and skips data.
  - Any other command: R1 with bit 2 set (illegal command).
- While the FSM is outside S_IDLE, received bytes are ignored and no new frame is accepted.
- During S_DATA, mem_idx advances when each byte completes. The prefetched byte is registered on the next clk.

## Timing
- Requirement on the host: spi_sck high and low phases each ≥ 4 clk; spi_ss set-up ≥ 4 clk before the first spi_sck rise.
- spi_miso is valid ≤ 3 clk after a spi_sck pin fall, and ≤ 3 clk after spi_ss rises (going to 1).
- cmd_valid asserts ≤ 4 clk after the 48th spi_sck pin rise of a frame.
- Memory latency: mem_din is sampled exactly 1 clk after an address change, and always ≥ 1 full byte time before that byte is shifted out.
- Reset values: spi_miso=1, mem_blk=0, mem_idx=0, cmd_valid=0, cmd_index=0, cmd_arg=0, busy=0, card_idle=1; ACMD41 count=0; FSM=S_IDLE.
- Asserting reset mid-transfer takes effect asynchronously with the values above. A partial byte is discarded.

## Test plan
- Reset, CMD0 (40 00 00 00 00 95), 2 filler bytes -> MISO FF, 01; cmd_valid pulse with cmd_index=0, cmd_arg=0.
- CMD8 arg 0x000001AA -> FF, 01, 00, 00, 01, AA.
- CMD55+ACMD41 twice -> R1 01 then R1 00; card_idle falls. Then CMD58 -> FF, 00, C0, FF, 80, 00.
- Memory byte = idx[7:0]^blk[7:0]; CMD17 arg 0x00002000 -> FF, 00, FF, FF, FE, 512 matching bytes, FF, FF; mem_blk=0x2000; busy low afterwards.
- CMD17 with spi_ss raised after 100 data bytes -> spi_miso=1 within 3 clk, busy=0. A repeated CMD17 restarts data at mem_idx 0.
- CMD13 after init -> R1 04. CMD17 before ACMD41 -> 05 with no token. Async reset mid-data -> spi_miso=1, card_idle=1 immediately.
